// File: rtl/sw_event_sender.sv
// Queues game events and hands them to the CPU one 32-bit word per 4-phase evt_sig/evt_ack handshake.
// One cycle from push to evt_sig; a full queue drops new events into a saturating drop_cnt.

module sw_event_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (!push_i && pop_i) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
endmodule

module sw_event_sender #(
   parameter int FIFO_DEPTH = 8,
   parameter int Y_MAX      = 480
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          evt_valid,
   output logic                          evt_ready,
   input  logic [3:0]                    evt_obj,
   input  logic [2:0]                    evt_type,
   input  logic [2:0]                    evt_code,
   input  logic [9:0]                    evt_x,
   input  logic [9:0]                    evt_y,
   output logic [31:0]                   evt_port,
   output logic [1:0]                    evt_sig,
   input  logic [1:0]                    evt_ack,
   output logic [$clog2(FIFO_DEPTH):0]   pending,
   output logic [7:0]                    drop_cnt
);
   typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_RELEASE} state_t;

   state_t      state_q, state_d;
   logic [31:0] port_q, port_d;
   logic [1:0]  sig_q, sig_d;
   logic [7:0]  drop_q, drop_d;
   logic        fifo_full, fifo_empty, push, pop;
   logic [31:0] wword, head;
   logic [9:0]  y_sw;

   // Software measures y from the bottom; out-of-range inputs clamp to 0 rather than wrap.
   assign y_sw  = (evt_y <= 10'(Y_MAX)) ? (10'(Y_MAX) - evt_y) : 10'd0;
   assign wword = {2'b00, y_sw, evt_x, evt_code, evt_type, evt_obj};
   assign push  = evt_valid && !fifo_full;

   sw_event_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wword),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (pending)
   );

   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      sig_d   = sig_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               port_d  = head;
               sig_d   = 2'd1;
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (evt_ack == 2'd1) begin
               sig_d   = 2'd0;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (evt_ack == 2'd0) state_d = S_IDLE;
         end
         default: begin
            sig_d   = 2'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      if (evt_valid && fifo_full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         port_q  <= '0;
         sig_q   <= 2'd0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         sig_q   <= sig_d;
         drop_q  <= drop_d;
      end
   end

   assign evt_ready = !fifo_full;
   assign evt_port  = port_q;
   assign evt_sig   = sig_q;
   assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_sw_event_sender.sv
// Bench for sw_event_sender: directed scenarios plus randomized traffic against a queue-based model.
module tb_sw_event_sender;
   localparam int DEPTH = 8;
   localparam int YMAX  = 480;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          evt_valid;
   logic          evt_ready;
   logic [3:0]    evt_obj;
   logic [2:0]    evt_type;
   logic [2:0]    evt_code;
   logic [9:0]    evt_x;
   logic [9:0]    evt_y;
   logic [31:0]   evt_port;
   logic [1:0]    evt_sig;
   logic [1:0]    evt_ack;
   logic [PW-1:0] pending;
   logic [7:0]    drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queue of accepted words, handshake phase (0 idle, 1 word shown, 2 awaiting release)
   logic [31:0] m_q[$];
   int          m_phase;
   logic [31:0] m_port;
   int          m_drop;

   always #5 clk = ~clk;

   sw_event_sender #(.FIFO_DEPTH(DEPTH), .Y_MAX(YMAX)) dut (
      .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_obj(evt_obj), .evt_type(evt_type), .evt_code(evt_code), .evt_x(evt_x),
      .evt_y(evt_y), .evt_port(evt_port), .evt_sig(evt_sig), .evt_ack(evt_ack),
      .pending(pending), .drop_cnt(drop_cnt)
   );

   function automatic logic [31:0] mk_word(input logic [3:0] o, input logic [2:0] t,
                                           input logic [2:0] c, input logic [9:0] x,
                                           input logic [9:0] y);
      int ys;
      ys = (int'(y) <= YMAX) ? (YMAX - int'(y)) : 0;
      return 32'(int'(o) + int'(t) * 16 + int'(c) * 128 + int'(x) * 1024 + ys * 1048576);
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_phase = 0;
      m_port  = '0;
      m_drop  = 0;
   endtask

   // Drive one cycle of inputs, step past the edge, then advance the model by the same rules.
   task automatic cycle(input logic v, input logic [3:0] o, input logic [2:0] t,
                        input logic [2:0] c, input logic [9:0] x, input logic [9:0] y,
                        input logic [1:0] a);
      bit was_full;
      evt_valid = v; evt_obj = o; evt_type = t; evt_code = c;
      evt_x = x; evt_y = y; evt_ack = a;
      @(posedge clk); #1;
      was_full = (m_q.size() == DEPTH);
      case (m_phase)
         0: if (m_q.size() > 0) begin m_port = m_q.pop_front(); m_phase = 1; end
         1: if (a == 2'd1) m_phase = 2;
         2: if (a == 2'd0) m_phase = 0;
         default: m_phase = 0;
      endcase
      if (v) begin
         if (!was_full) m_q.push_back(mk_word(o, t, c, x, y));
         else if (m_drop < 255) m_drop++;
      end
   endtask

   task automatic idle(input logic [1:0] a);
      cycle(1'b0, 4'd0, 3'd0, 3'd0, 10'd0, 10'd0, a);
   endtask

   task automatic do_reset();
      evt_valid = 1'b0; evt_ack = 2'd0;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b0; evt_valid = 1'b0; evt_ack = 2'd0;
      evt_obj = '0; evt_type = '0; evt_code = '0; evt_x = '0; evt_y = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (evt_sig !== 2'd0) begin n_bad++; $display("FAIL reset_sig got %0d want 0", evt_sig); end
      n_cmp++; if (evt_port !== 32'd0) begin n_bad++; $display("FAIL reset_port got %h want 0", evt_port); end
      n_cmp++; if (pending !== PW'(0)) begin n_bad++; $display("FAIL reset_pending got %0d want 0", pending); end
      n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
      reset = 1'b1;
      #1;
      n_cmp++; if (evt_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", evt_ready); end
   endtask

   task automatic test_single();
      logic [31:0] w;
      w = mk_word(4'd5, 3'd2, 3'd1, 10'd100, 10'd80);
      cycle(1'b1, 4'd5, 3'd2, 3'd1, 10'd100, 10'd80, 2'd0);
      n_cmp++; if (evt_sig !== 2'd0) begin n_bad++; $display("FAIL single_sig_at_push got %0d want 0", evt_sig); end
      n_cmp++; if (pending !== PW'(m_q.size())) begin n_bad++; $display("FAIL single_pending_push got %0d want %0d", pending, m_q.size()); end
      idle(2'd0);
      n_cmp++; if (evt_sig !== 2'd1) begin n_bad++; $display("FAIL single_sig_rise got %0d want 1", evt_sig); end
      n_cmp++; if (evt_port !== w) begin n_bad++; $display("FAIL single_port got %h want %h", evt_port, w); end
      n_cmp++; if (pending !== PW'(0)) begin n_bad++; $display("FAIL single_pending got %0d want 0", pending); end
      repeat (2) begin
         idle(2'd0);
         n_cmp++; if (evt_sig !== 2'd1) begin n_bad++; $display("FAIL single_sig_hold got %0d want 1", evt_sig); end
      end
      idle(2'd1);
      n_cmp++; if (evt_sig !== 2'd0) begin n_bad++; $display("FAIL single_sig_after_ack got %0d want 0", evt_sig); end
      n_cmp++; if (evt_port !== w) begin n_bad++; $display("FAIL single_port_release got %h want %h", evt_port, w); end
      idle(2'd1);
      idle(2'd0);
      idle(2'd0);
      n_cmp++; if (evt_sig !== 2'd0) begin n_bad++; $display("FAIL single_sig_idle got %0d want 0", evt_sig); end
   endtask

   task automatic test_fill_drop();
      logic [31:0] exp_w[$];
      logic [3:0] o; logic [2:0] t, c; logic [9:0] x, y;
      logic [1:0] ps;
      int got;
      for (int i = 0; i < 10; i++) begin
         o = 4'($urandom); t = 3'($urandom); c = 3'($urandom);
         x = 10'($urandom); y = 10'($urandom_range(0, 600));
         if (i < 9) exp_w.push_back(mk_word(o, t, c, x, y));
         cycle(1'b1, o, t, c, x, y, 2'd0);
      end
      n_cmp++; if (pending !== PW'(DEPTH)) begin n_bad++; $display("FAIL fill_pending got %0d want %0d", pending, DEPTH); end
      n_cmp++; if (evt_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready got %b want 0", evt_ready); end
      n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL fill_drop got %0d want 1", drop_cnt); end
      n_cmp++; if (evt_sig !== 2'd1) begin n_bad++; $display("FAIL fill_sig got %0d want 1", evt_sig); end
      got = 0;
      if (evt_sig == 2'd1) begin
         n_cmp++; if (evt_port !== exp_w[0]) begin n_bad++; $display("FAIL fill_word0 got %h want %h", evt_port, exp_w[0]); end
         got = 1;
      end
      for (int i = 0; i < 100 && got < 9; i++) begin
         ps = evt_sig;
         idle((evt_sig == 2'd1) ? 2'd1 : 2'd0);
         if (ps == 2'd0 && evt_sig == 2'd1) begin
            n_cmp++; if (evt_port !== exp_w[got]) begin n_bad++; $display("FAIL fill_word%0d got %h want %h", got, evt_port, exp_w[got]); end
            got++;
         end
      end
      n_cmp++; if (got != 9) begin n_bad++; $display("FAIL fill_delivered got %0d want 9", got); end
      idle(2'd1); idle(2'd0); idle(2'd0);
      n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL fill_drop_after got %0d want 1", drop_cnt); end
      n_cmp++; if (pending !== PW'(0)) begin n_bad++; $display("FAIL fill_pending_after got %0d want 0", pending); end
   endtask

   task automatic test_y_clamp();
      logic [9:0] ys_in[3];
      logic [9:0] ys_exp[3];
      logic [1:0] ps;
      int got;
      ys_in[0] = 10'd500; ys_in[1] = 10'd0;   ys_in[2] = 10'd480;
      ys_exp[0] = 10'd0;  ys_exp[1] = 10'd480; ys_exp[2] = 10'd0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i), 3'd1, 3'd2, 10'd7, ys_in[i], 2'd0);
      got = 0;
      if (evt_sig == 2'd1) begin
         n_cmp++; if (evt_port[29:20] !== ys_exp[0]) begin n_bad++; $display("FAIL y_sw0 got %0d want %0d", evt_port[29:20], ys_exp[0]); end
         got = 1;
      end
      for (int i = 0; i < 40 && got < 3; i++) begin
         ps = evt_sig;
         idle((evt_sig == 2'd1) ? 2'd1 : 2'd0);
         if (ps == 2'd0 && evt_sig == 2'd1) begin
            n_cmp++; if (evt_port[29:20] !== ys_exp[got]) begin n_bad++; $display("FAIL y_sw%0d got %0d want %0d", got, evt_port[29:20], ys_exp[got]); end
            n_cmp++; if (evt_port[31:30] !== 2'b00) begin n_bad++; $display("FAIL y_top_bits got %b want 00", evt_port[31:30]); end
            got++;
         end
      end
      n_cmp++; if (got != 3) begin n_bad++; $display("FAIL y_delivered got %0d want 3", got); end
      idle(2'd1); idle(2'd0); idle(2'd0);
   endtask

   task automatic test_ack_ignored();
      logic [31:0] w;
      w = mk_word(4'd9, 3'd3, 3'd4, 10'd321, 10'd123);
      cycle(1'b1, 4'd9, 3'd3, 3'd4, 10'd321, 10'd123, 2'd0);
      idle(2'd0);
      for (int i = 0; i < 5; i++) begin
         idle(2'd2);
         n_cmp++; if (evt_sig !== 2'd1) begin n_bad++; $display("FAIL ackign_sig got %0d want 1", evt_sig); end
         n_cmp++; if (evt_port !== w) begin n_bad++; $display("FAIL ackign_port got %h want %h", evt_port, w); end
      end
      idle(2'd1);
      n_cmp++; if (evt_sig !== 2'd0) begin n_bad++; $display("FAIL ackign_proceed got %0d want 0", evt_sig); end
      idle(2'd3);
      idle(2'd0);
      idle(2'd0);
      n_cmp++; if (evt_sig !== 2'd0) begin n_bad++; $display("FAIL ackign_idle got %0d want 0", evt_sig); end
   endtask

   task automatic test_async_reset();
      logic [31:0] w;
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 4'(i + 1), 3'd5, 3'd6, 10'(i * 50), 10'd200, 2'd0);
      n_cmp++; if (evt_sig !== 2'd1) begin n_bad++; $display("FAIL arst_pre_sig got %0d want 1", evt_sig); end
      n_cmp++; if (pending !== PW'(3)) begin n_bad++; $display("FAIL arst_pre_pending got %0d want 3", pending); end
      evt_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (evt_sig !== 2'd0) begin n_bad++; $display("FAIL arst_sig got %0d want 0", evt_sig); end
      n_cmp++; if (evt_port !== 32'd0) begin n_bad++; $display("FAIL arst_port got %h want 0", evt_port); end
      n_cmp++; if (pending !== PW'(0)) begin n_bad++; $display("FAIL arst_pending got %0d want 0", pending); end
      model_clear();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      w = mk_word(4'd12, 3'd7, 3'd3, 10'd999, 10'd1000);
      cycle(1'b1, 4'd12, 3'd7, 3'd3, 10'd999, 10'd1000, 2'd0);
      idle(2'd0);
      n_cmp++; if (evt_sig !== 2'd1) begin n_bad++; $display("FAIL arst_after_sig got %0d want 1", evt_sig); end
      n_cmp++; if (evt_port !== w) begin n_bad++; $display("FAIL arst_after_port got %h want %h", evt_port, w); end
      idle(2'd1); idle(2'd0); idle(2'd0);
   endtask

   task automatic test_drop_saturate();
      int prev;
      int nonmono;
      nonmono = 0;
      prev = int'(drop_cnt);
      for (int i = 0; i < 300; i++) begin
         cycle(1'b1, 4'($urandom), 3'($urandom), 3'($urandom), 10'($urandom), 10'($urandom), 2'd0);
         if (int'(drop_cnt) < prev) nonmono++;
         prev = int'(drop_cnt);
      end
      n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
      n_cmp++; if (nonmono != 0) begin n_bad++; $display("FAIL drop_wrap got %0d decreases want 0", nonmono); end
      n_cmp++; if (evt_ready !== 1'b0) begin n_bad++; $display("FAIL drop_ready got %b want 0", evt_ready); end
   endtask

   task automatic test_random();
      logic v;
      int bad_before;
      do_reset();
      bad_before = n_bad;
      for (int i = 0; i < 2000; i++) begin
         v = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle(v, 4'($urandom), 3'($urandom), 3'($urandom), 10'($urandom),
               10'($urandom_range(0, 1023)), 2'($urandom));
         n_cmp++; if (evt_sig !== ((m_phase == 1) ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL rand_sig cyc %0d got %0d want %0d", i, evt_sig, (m_phase == 1)); end
         n_cmp++; if (evt_port !== m_port) begin n_bad++; $display("FAIL rand_port cyc %0d got %h want %h", i, evt_port, m_port); end
         n_cmp++; if (pending !== PW'(m_q.size())) begin n_bad++; $display("FAIL rand_pending cyc %0d got %0d want %0d", i, pending, m_q.size()); end
         n_cmp++; if (evt_ready !== (m_q.size() < DEPTH)) begin n_bad++; $display("FAIL rand_ready cyc %0d got %b want %b", i, evt_ready, (m_q.size() < DEPTH)); end
         n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_bad++; $display("FAIL rand_drop cyc %0d got %0d want %0d", i, drop_cnt, m_drop); end
         if (n_bad - bad_before > 30) break;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drop();
      test_y_clamp();
      test_ack_ignored();
      test_async_reset();
      test_drop_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
